// File: rtl/fir_pkg.sv
// Shared constants, sample type and rounding/saturating narrow helper for the FIR chain.
package fir_pkg;

  localparam int unsigned FIR_DW    = 32;
  localparam int unsigned FIR_OW    = 16;
  localparam int unsigned FIR_SHIFT = 8;
  localparam int unsigned FIR_DEPTH = 16;

  typedef logic signed [FIR_DW-1:0] sample_t;

  // Round half-up, arithmetic shift, saturate to a signed ow-bit range; one guard bit.
  function automatic sample_t narrow_rs(input sample_t value, input int unsigned shift,
                                        input int unsigned ow);
    logic signed [FIR_DW:0] ext;
    logic signed [FIR_DW:0] rnd;
    logic signed [FIR_DW:0] t;
    logic signed [FIR_DW:0] one;
    logic signed [FIR_DW:0] max_v;
    logic signed [FIR_DW:0] min_v;
    ext   = value;
    one   = 1;
    rnd   = one <<< (shift - 1);
    t     = (ext + rnd) >>> shift;
    max_v = (one <<< (ow - 1)) - one;
    min_v = -max_v - one;
    if (t > max_v) begin
      t = max_v;
    end else if (t < min_v) begin
      t = min_v;
    end
    return t[FIR_DW-1:0];
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with explicit occupancy count and synchronous flush.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int unsigned W     = FIR_OW,
  parameter int unsigned DEPTH = FIR_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          wr_en, rd_en;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr_q];
  assign level = level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Runtime-ratio decimator, sample narrowing and output FIFO behind a ready/valid port.
// Define FIR_DECIM_ROUND_SAT_EN for round-half-up with saturation instead of truncation.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned OW    = FIR_OW,
  parameter int unsigned SHIFT = FIR_SHIFT,
  parameter int unsigned DEPTH = FIR_DEPTH,
  parameter int unsigned RW    = 6,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [RW-1:0]        ratio,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic [OW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        level,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  logic [RW-1:0] phase_q, phase_d, ratio_q, ratio_d, eff_ratio, period;
  logic          kept, push, pop, full, empty, ovf_event, overflow_q;
  logic [OW-1:0] wdata;

  // The period length is captured when phase 0 is consumed so ratio edits land at the wrap.
  always_comb begin
    eff_ratio = (ratio == '0) ? RW'(1) : ratio;
    period    = (phase_q == '0) ? eff_ratio : ratio_q;
    kept      = enable & in_valid & (phase_q == '0);
    phase_d   = phase_q;
    ratio_d   = ratio_q;
    if (!enable || flush) begin
      phase_d = '0;
    end else if (in_valid) begin
      if (phase_q == '0) ratio_d = eff_ratio;
      phase_d = (phase_q == period - RW'(1)) ? '0 : phase_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      ratio_q <= '0;
    end else begin
      phase_q <= phase_d;
      ratio_q <= ratio_d;
    end
  end

`ifdef FIR_DECIM_ROUND_SAT_EN
  sample_t narrowed;
  assign narrowed = narrow_rs(sample_t'(in_data), SHIFT, OW);
  assign wdata    = narrowed[OW-1:0];
`else
  assign wdata = OW'(in_data >>> SHIFT);
`endif

  assign push      = kept & ~flush;
  assign pop       = ~empty & out_ready;
  assign ovf_event = push & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (ovf_event) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  fir_sync_fifo #(
    .W     (OW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: directed scenarios plus a randomized run against a queue model.
module tb_fir_decim_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SHIFT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, flush, in_valid, out_ready, clr_ovf;
  logic [5:0]  ratio;
  logic [31:0] in_data;
  logic [15:0] out_data;
  logic        out_valid, overflow;
  logic [4:0]  level;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_q[$];
  bit          m_ovf;
  int          m_rem;

  always #5 clk = ~clk;

  fir_decim_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .ratio     (ratio),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  function automatic logic [15:0] m_narrow(input logic [31:0] d);
    longint t;
    t = longint'($signed(d));
`ifdef FIR_DECIM_ROUND_SAT_EN
    t = (t + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (t > 32767) t = 32767;
    else if (t < -32768) t = -32768;
`else
    t = t >>> SHIFT;
`endif
    return t[15:0];
  endfunction

  // Model: m_rem counts the samples still to skip before the next kept one.
  function automatic void model_clock();
    bit pop, kept, evt;
    int eff;
    pop  = (m_q.size() != 0) && out_ready;
    kept = 1'b0;
    eff  = (ratio == 0) ? 1 : int'(ratio);
    if (!enable) m_rem = 0;
    else if (in_valid) begin
      if (m_rem == 0) begin
        kept  = 1'b1;
        m_rem = eff - 1;
      end else m_rem--;
    end
    if (flush) begin
      m_q.delete();
      m_rem = 0;
      if (clr_ovf) m_ovf = 1'b0;
    end else begin
      evt = kept && (m_q.size() == DEPTH) && !pop;
      if (pop) void'(m_q.pop_front());
      if (kept && !evt) m_q.push_back(m_narrow(in_data));
      if (evt) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  endfunction

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    in_valid = 1'b0; flush = 1'b1; clr_ovf = 1'b1;
    step();
    flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clr_ovf = 1'b0; ratio = '0; in_data = '0;
    m_q.delete(); m_ovf = 1'b0; m_rem = 0;
    #13;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_decimate();
    logic [15:0] got[$];
    logic [15:0] exp_seq[4];
    exp_seq = '{16'd0, 16'd4, 16'd8, 16'd12};
    enable = 1'b1; ratio = 6'd4; out_ready = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_data = 32'(n) << 8;
      step();
      if (out_valid) got.push_back(out_data);
      if (n % 4 == 0) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'(n)) begin
          n_err++; $display("FAIL dec_latency n=%0d: got v=%b d=%0h want v=1 d=%0h", n, out_valid, out_data, n);
        end
      end
      n_vec++; if (level > 5'd1) begin n_err++; $display("FAIL dec_level: got %0d want <=1", level); end
    end
    n_vec++;
    if (got.size() != 4) begin n_err++; $display("FAIL dec_count: got %0d want 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (got[i] !== exp_seq[i]) begin n_err++; $display("FAIL dec_seq[%0d]: got %0h want %0h", i, got[i], exp_seq[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_ratio_zero_one();
    for (int r = 0; r < 2; r++) begin
      quiesce();
      ratio = 6'(r); out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0300;
      for (int i = 0; i < 4; i++) begin
        step();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003) begin
          n_err++; $display("FAIL ratio%0d_keep i=%0d: got v=%b d=%0h want v=1 d=0003", r, i, out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] saved[17];
    quiesce();
    ratio = 6'd1; out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      saved[i] = $urandom; in_data = saved[i]; in_valid = 1'b1;
      step();
      n_vec++;
      if (level !== 5'((i < 16) ? i + 1 : 16)) begin n_err++; $display("FAIL ovf_level i=%0d: got %0d", i, level); end
      n_vec++;
      if (overflow !== (i == 16)) begin n_err++; $display("FAIL ovf_flag i=%0d: got %b want %b", i, overflow, i == 16); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (out_data !== m_narrow(saved[i])) begin
        n_err++; $display("FAIL ovf_drain[%0d]: got %0h want %0h", i, out_data, m_narrow(saved[i]));
      end
      step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_q[$];
    logic [31:0] d;
    quiesce();
    ratio = 6'd1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = $urandom; in_data = d; exp_q.push_back(m_narrow(d));
      step();
    end
    d = $urandom; in_data = d; out_ready = 1'b1;
    void'(exp_q.pop_front()); exp_q.push_back(m_narrow(d));
    step();
    n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL fpp_level: got %0d want 16", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
        n_err++; $display("FAIL fpp_drain[%0d]: got v=%b d=%0h want %0h", i, out_valid, out_data, exp_q[i]);
      end
      step();
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    quiesce();
    ratio = 6'd1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 11; i++) step();
    out_ready = 1'b0;
    n_vec++; if (level !== 5'd5) begin n_err++; $display("FAIL flush_pre_level: got %0d want 5", level); end
    ratio = 6'd3; flush = 1'b1; in_valid = 1'b1; in_data = $urandom;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL flush_ovf: got %b want 1", overflow); end
    d = $urandom; in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (level !== 5'd1 || out_data !== m_narrow(d)) begin
      n_err++; $display("FAIL flush_next: got l=%0d d=%0h want l=1 d=%0h", level, out_data, m_narrow(d));
    end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
  endtask

  task automatic test_narrow();
    logic [31:0] vin[3];
    logic [15:0] vexp[3];
    vin = '{32'h0000_0180, 32'h7FFF_FFFF, 32'h8000_0000};
`ifdef FIR_DECIM_ROUND_SAT_EN
    vexp = '{16'h0002, 16'h7FFF, 16'h8000};
`else
    vexp = '{16'h0001, 16'hFFFF, 16'h0000};
`endif
    quiesce();
    ratio = 6'd1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vin[i]; in_valid = 1'b1;
      step();
      n_vec++;
      if (out_data !== vexp[i]) begin n_err++; $display("FAIL narrow %h: got %0h want %0h", vin[i], out_data, vexp[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    quiesce();
    for (int c = 0; c < 600; c++) begin
      enable    = ($urandom_range(0, 15) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      clr_ovf   = ($urandom_range(0, 30) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      in_data   = $urandom;
      if ($urandom_range(0, 20) == 0) ratio = 6'($urandom_range(0, 5));
      step();
      n_vec++;
      if (level !== 5'(m_q.size()) || out_valid !== (m_q.size() != 0) || overflow !== m_ovf) begin
        n_err++; $display("FAIL rand_state c=%0d: got l=%0d v=%b o=%b want l=%0d o=%b",
                          c, level, out_valid, overflow, m_q.size(), m_ovf);
      end else if (m_q.size() != 0 && out_data !== m_q[0]) begin
        n_err++; $display("FAIL rand_data c=%0d: got %0h want %0h", c, out_data, m_q[0]);
      end
    end
    flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_async_reset();
    quiesce();
    ratio = 6'd1; out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin in_data = $urandom; step(); end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got l=%0d v=%b o=%b want 0 0 0", level, out_valid, overflow);
    end
    m_q.delete(); m_ovf = 1'b0; m_rem = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_decimate();
    test_ratio_zero_one();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_narrow();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
